// File: rtl/rvv_vrf_snap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvv_vrf_snap_pkg
// Brief    : Shared types and helpers for the VRF snapshot reader.
// Revision : 1.0
// ============================================================================
package rvv_vrf_snap_pkg;

  localparam int VLEN_DEF     = 128;
  localparam int NUM_VREG_DEF = 32;
  localparam int VREG_IDX_W   = $clog2(NUM_VREG_DEF);

  typedef logic [VLEN_DEF-1:0] vreg_t;
  typedef logic [7:0]          epoch_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_QUIET = 2'd1,
    ST_STREAM     = 2'd2,
    ST_DONE       = 2'd3
  } snap_state_t;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvv_vrf_ffs.sv
`default_nettype none
// ============================================================================
// Module   : rvv_vrf_ffs
// Brief    : Combinational find-first-set with a more-than-one-bit flag.
// Revision : 1.0
// ============================================================================
module rvv_vrf_ffs #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             more_than_one
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign found         = |vec;
  assign more_than_one = |(vec & (vec - N'(1)));

endmodule
`default_nettype wire

// File: rtl/rvv_vrf_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : rvv_vrf_snapshot_reader
// Brief    : Waits for retire quiescence, captures the VRF and streams the
//            selected registers out one per beat.
// Revision : 1.0
// ============================================================================
module rvv_vrf_snapshot_reader
  import rvv_vrf_snap_pkg::*;
#(
  parameter int VLEN          = 128,
  parameter int NUM_VREG      = 32,
  parameter int NUM_RT_UOP    = 4,
  parameter int QUIET_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_VREG*VLEN-1:0]     vrf_rd_data_full,
  input  logic [NUM_RT_UOP-1:0]        rt_uop,
  input  logic [NUM_RT_UOP-1:0]        rt_last_uop,
  input  logic                         snap_req,
  input  logic [NUM_VREG-1:0]          snap_mask,
  output logic                         snap_busy,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [$clog2(NUM_VREG)-1:0]  dump_idx,
  output logic [VLEN-1:0]              dump_data,
  output logic                         dump_last,
  output logic                         snap_done,
  output logic                         snap_forced,
  output logic [7:0]                   snap_epoch,
  output logic [15:0]                  last_uop_cnt
);

  localparam int IDX_W = $clog2(NUM_VREG);
  localparam int QW    = $clog2(QUIET_TIMEOUT);
  localparam logic [QW-1:0] C_QUIET_LAST = QW'(QUIET_TIMEOUT - 1);

  snap_state_t         r_state;
  logic [NUM_VREG-1:0] r_mask;
  logic [QW-1:0]       r_quiet_cnt;
  logic [15:0]         r_run_cnt;
  logic [15:0]         r_last_cnt;
  logic                r_forced;
  epoch_t              r_epoch;
  logic [VLEN-1:0]     r_shadow [NUM_VREG];

  logic                w_rt_quiet;
  logic                w_timeout;
  logic                w_capture;
  logic [5:0]          w_pc;
  logic [16:0]         w_run_sum;
  logic [15:0]         w_run_next;
  logic [IDX_W-1:0]    w_ffs_idx;
  logic                w_ffs_found;
  logic                w_ffs_more;
  logic                w_streaming;

  assign w_rt_quiet = (rt_uop == '0);
  assign w_timeout  = (r_quiet_cnt == C_QUIET_LAST);
  assign w_capture  = (r_state == ST_WAIT_QUIET) && (w_rt_quiet || w_timeout);

  // Saturating accumulation of retired last-uops for this cycle.
  assign w_pc       = popcnt32(32'(rt_uop & rt_last_uop));
  assign w_run_sum  = {1'b0, r_run_cnt} + {11'd0, w_pc};
  assign w_run_next = w_run_sum[16] ? 16'hFFFF : w_run_sum[15:0];

  rvv_vrf_ffs #(
    .N     (NUM_VREG),
    .IDX_W (IDX_W)
  ) u_ffs (
    .vec           (r_mask),
    .idx           (w_ffs_idx),
    .found         (w_ffs_found),
    .more_than_one (w_ffs_more)
  );

  assign w_streaming = (r_state == ST_STREAM) && w_ffs_found;

  // Shadow copy carries no reset; it is only read while streaming.
  generate
    for (genvar g = 0; g < NUM_VREG; g++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (w_capture) begin
          r_shadow[g] <= vrf_rd_data_full[g*VLEN +: VLEN];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt <= '0;
    end else if (w_capture) begin
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= w_run_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_quiet_cnt <= '0;
      r_last_cnt  <= '0;
      r_forced    <= 1'b0;
      r_epoch     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (snap_req) begin
            r_mask   <= snap_mask;
            r_forced <= 1'b0;
            r_state  <= ST_WAIT_QUIET;
          end
        end
        ST_WAIT_QUIET: begin
          if (w_capture) begin
            r_last_cnt  <= w_run_next;
            r_forced    <= !w_rt_quiet;
            r_quiet_cnt <= '0;
            r_state     <= (r_mask == '0) ? ST_DONE : ST_STREAM;
          end else begin
            r_quiet_cnt <= r_quiet_cnt + QW'(1);
          end
        end
        ST_STREAM: begin
          if (dump_ready) begin
            r_mask[w_ffs_idx] <= 1'b0;
            if (!w_ffs_more) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_epoch <= r_epoch + 8'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign snap_busy    = (r_state != ST_IDLE);
  assign snap_done    = (r_state == ST_DONE);
  assign snap_forced  = r_forced;
  assign snap_epoch   = r_epoch;
  assign last_uop_cnt = r_last_cnt;

  // Payload is zeroed outside STREAM so idle outputs read as reset values.
  assign dump_valid = w_streaming;
  assign dump_idx   = w_streaming ? w_ffs_idx : '0;
  assign dump_data  = w_streaming ? r_shadow[w_ffs_idx] : '0;
  assign dump_last  = w_streaming && !w_ffs_more;

endmodule
`default_nettype wire

// File: tb/tb_rvv_vrf_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvv_vrf_snapshot_reader
// Brief    : Scoreboard bench for the VRF snapshot reader.
// Revision : 1.0
// ============================================================================
module tb_rvv_vrf_snapshot_reader;

  localparam int VLEN = 128;
  localparam int NV   = 32;
  localparam int NRT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NV*VLEN-1:0] vrf_flat;
  logic [NRT-1:0]    rt_uop, rt_last_uop;
  logic              snap_req;
  logic [NV-1:0]     snap_mask;
  logic              snap_busy, dump_valid, dump_ready, dump_last, snap_done, snap_forced;
  logic [4:0]        dump_idx;
  logic [VLEN-1:0]   dump_data;
  logic [7:0]        snap_epoch;
  logic [15:0]       last_uop_cnt;

  always #5 clk = ~clk;

  rvv_vrf_snapshot_reader #(
    .VLEN(VLEN), .NUM_VREG(NV), .NUM_RT_UOP(NRT), .QUIET_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vrf_rd_data_full(vrf_flat),
    .rt_uop(rt_uop), .rt_last_uop(rt_last_uop),
    .snap_req(snap_req), .snap_mask(snap_mask), .snap_busy(snap_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_last(dump_last), .snap_done(snap_done),
    .snap_forced(snap_forced), .snap_epoch(snap_epoch), .last_uop_cnt(last_uop_cnt)
  );

  logic [VLEN-1:0] vrf [NV];
  always_comb begin
    vrf_flat = '0;
    for (int i = 0; i < NV; i++) vrf_flat[i*VLEN +: VLEN] = vrf[i];
  end

  typedef struct { int idx; logic [VLEN-1:0] data; bit last; } beat_t;
  typedef struct { bit forced; int cnt; bit nonempty; } done_t;
  beat_t exp_beats[$];
  done_t exp_done[$];

  int n_checks = 0, n_fail = 0;
  int model_epoch = 0, done_cnt = 0, beats_acc = 0, model_run = 0;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture intent from the stimulus: the model snapshots its own VRF copy.
  bit            cap_now = 0, cap_forced = 0;
  logic [NV-1:0] cap_mask = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_run = 0;
    end else begin
      int pc, sum;
      beat_t bb;
      done_t dd;
      pc  = $countones(rt_uop & rt_last_uop);
      sum = (model_run + pc > 65535) ? 65535 : model_run + pc;
      if (cap_now) begin
        dd.forced = cap_forced; dd.cnt = sum; dd.nonempty = (cap_mask != 0);
        exp_done.push_back(dd);
        for (int i = 0; i < NV; i++) begin
          if (cap_mask[i]) begin
            bb.idx = i; bb.data = vrf[i]; bb.last = ((cap_mask >> (i + 1)) == 0);
            exp_beats.push_back(bb);
          end
        end
        model_run = 0;
      end else begin
        model_run = sum;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a beat or done.
  bit              stalled_prev = 0, last_prev = 0;
  logic [4:0]      held_idx;
  logic [VLEN-1:0] held_data;
  logic            held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 0;
      last_prev    = 0;
    end else begin
      beat_t b;
      done_t d;
      chk("epoch", snap_epoch, model_epoch[7:0]);
      if (dump_valid) begin
        if (stalled_prev) begin
          chk("stall_idx", dump_idx, held_idx);
          chk("stall_data", dump_data, held_data);
          chk("stall_last", dump_last, held_last);
        end
        if (dump_ready) begin
          if (exp_beats.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got idx %0d expected none", dump_idx);
          end else begin
            b = exp_beats.pop_front();
            chk("beat_idx", dump_idx, b.idx[4:0]);
            chk("beat_data", dump_data, b.data);
            chk("beat_last", dump_last, b.last);
          end
          beats_acc++;
          stalled_prev = 0;
        end else begin
          stalled_prev = 1;
          held_idx = dump_idx; held_data = dump_data; held_last = dump_last;
        end
      end else begin
        stalled_prev = 0;
      end
      if (snap_done) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got pulse expected none");
        end else begin
          d = exp_done.pop_front();
          chk("done_forced", snap_forced, d.forced);
          chk("done_last_uop_cnt", last_uop_cnt, d.cnt);
          chk("done_beats_drained", exp_beats.size(), 0);
          if (d.nonempty) chk("done_after_last", last_prev, 1);
        end
        model_epoch = (model_epoch + 1) % 256;
        done_cnt++;
      end
      last_prev = dump_valid && dump_ready && dump_last;
    end
  end

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rt_uop = '0; rt_last_uop = '0; dump_ready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // One snapshot: pre-request retires, request, WAIT_QUIET, then stream.
  task automatic run_snap(input logic [NV-1:0] mask, input int pre_n, input logic [3:0] pre_pat,
                          input int busy_n, input logic [3:0] busy_pat, input logic [3:0] busy_last,
                          input int ready_mode, input int rewrite_at, input bit second_req,
                          input bit rnd);
    int  cyc, base;
    bit  cap;
    for (int i = 0; i < pre_n; i++) begin
      rt_uop = pre_pat; rt_last_uop = pre_pat;
      @(posedge clk); #1;
    end
    rt_uop = '0; rt_last_uop = '0;
    snap_req = 1'b1; snap_mask = mask;
    @(posedge clk); #1;
    snap_req = 1'b0; snap_mask = NV'($urandom);
    cyc = 1;
    for (int w = 0; w < 64; w++) begin
      if (w < busy_n) begin rt_uop = busy_pat; rt_last_uop = busy_last; end
      else begin rt_uop = '0; rt_last_uop = '0; end
      if (second_req && w == 0) snap_req = 1'b1;
      if (cyc == rewrite_at) vrf[5] = {4{32'hDEAD_0005}};
      if (rnd) vrf[$urandom_range(0, NV - 1)] = rnd128();
      cap = (rt_uop == '0) || (w == 63);
      cap_now = cap; cap_forced = (rt_uop != '0); cap_mask = mask;
      @(posedge clk); #1;
      cap_now = 0; snap_req = 1'b0; cyc++;
      if (cap) break;
    end
    base = done_cnt;
    for (int k = 0; k < 400 && done_cnt == base; k++) begin
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (k % 4 == 0) || (k % 4 == 3);
        default: dump_ready = 1'($urandom);
      endcase
      if (rnd) begin
        rt_uop = NRT'($urandom); rt_last_uop = NRT'($urandom);
        vrf[$urandom_range(0, NV - 1)] = rnd128();
      end else begin
        rt_uop = '0; rt_last_uop = '0;
      end
      if (cyc == rewrite_at) vrf[5] = {4{32'hDEAD_0005}};
      if (k == 0 && mask != 0 && busy_n == 0) chk("min_latency_valid", dump_valid, 1);
      @(posedge clk); #1;
      cyc++;
    end
    if (done_cnt == base) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no snap_done expected one within 400 cycles");
    end
    rt_uop = '0; rt_last_uop = '0;
    chk("busy_after_done", snap_busy, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; snap_req = 1'b0; snap_mask = '0; dump_ready = 1'b0;
    rt_uop = '0; rt_last_uop = '0;
    for (int i = 0; i < NV; i++) vrf[i] = {4{32'hA5A5_0000 + 32'(i)}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", snap_busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", snap_done, 0);
    chk("rst_epoch", snap_epoch, 0);
    chk("rst_cnt", last_uop_cnt, 0);
    chk("rst_data", dump_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Retire counting, empty mask and an ignored request while busy.
    run_snap('0, 7, 4'b0101, 0, 4'b0, 4'b0, 0, -1, 1'b1, 1'b0);
    chk("cnt_fourteen", last_uop_cnt, 16'd14);
    idle(2);

    // Full-register dump with ready held high.
    run_snap('1, 0, 4'b0, 0, 4'b0, 4'b0, 0, -1, 1'b0, 1'b0);
    idle(2);

    // Sparse mask with backpressure.
    run_snap(32'h8000_0011, 0, 4'b0, 0, 4'b0, 4'b0, 1, -1, 1'b0, 1'b0);
    idle(2);

    // Quiescence wait; reg 5 rewritten after capture.
    run_snap(32'h0000_0121, 0, 4'b0, 10, 4'b0011, 4'b0011, 0, 12, 1'b0, 1'b0);
    chk("quiet_not_forced", snap_forced, 0);
    idle(2);

    // Forced capture under continuous retire activity.
    for (int i = 0; i < NV; i++) vrf[i] = rnd128();
    run_snap(32'h0F00_00F0, 0, 4'b0, 100, 4'b0011, 4'b0000, 2, -1, 1'b0, 1'b1);
    idle(3);
    chk("forced_held", snap_forced, 1);

    // Reset in the middle of a full dump.
    for (int i = 0; i < NV; i++) vrf[i] = {4{32'hA5A5_0000 + 32'(i)}};
    dump_ready = 1'b1;
    snap_req = 1'b1; snap_mask = '1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    cap_now = 1; cap_forced = 0; cap_mask = '1;
    @(posedge clk); #1;
    cap_now = 0;
    base = beats_acc;
    for (int k = 0; k < 50 && beats_acc - base < 3; k++) begin
      @(posedge clk); #1;
    end
    if (beats_acc - base < 3) begin
      n_checks++; n_fail++;
      $display("FAIL reset_prep_timeout: got %0d beats expected 3", beats_acc - base);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", dump_valid, 0);
    chk("midrst_busy", snap_busy, 0);
    chk("midrst_epoch", snap_epoch, 0);
    chk("midrst_done", snap_done, 0);
    exp_beats.delete();
    exp_done.delete();
    model_epoch = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_snap('1, 0, 4'b0, 0, 4'b0, 4'b0, 0, -1, 1'b0, 1'b0);
    idle(2);

    // Randomised snapshots with live VRF traffic.
    for (int t = 0; t < 8; t++) begin
      logic [NV-1:0] m;
      int busy;
      m    = ($urandom_range(0, 5) == 0) ? '0 : NV'($urandom);
      busy = ($urandom_range(0, 4) == 0) ? 80 : $urandom_range(0, 12);
      run_snap(m, $urandom_range(0, 5), NRT'($urandom), busy, NRT'($urandom_range(1, 15)),
               NRT'($urandom), 2, -1, 1'($urandom), 1'b1);
      idle($urandom_range(1, 4));
    end

    idle(3);
    chk("end_beats_empty", exp_beats.size(), 0);
    chk("end_done_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rvv_vrf_snapshot_reader.md
Name: rvv_vrf_snapshot_reader

Overview:
- Read-side counterpart to the testbench VRF backdoor writer.
- On request, waits for retire quiescence, then captures the DUT's full VRF read view (vrf_rd_data_full) into a shadow buffer.
- Streams the selected registers out one per beat over a valid/ready port to the checker/scoreboard path.
- Sits beside the VRF in the backend TB harness; is synthesizable so it can also serve as an on-chip debug dump engine.

Parameters:
- VLEN, 128, vector register width in bits.
- NUM_VREG, 32, number of architectural vector registers (idx width = $clog2(NUM_VREG)).
- NUM_RT_UOP, 4, retire uop lanes observed.
- QUIET_TIMEOUT, 64, maximum WAIT_QUIET cycles before a forced capture (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- vrf_rd_data_full  in  NUM_VREG*VLEN  live VRF contents; reg i occupies bits [i*VLEN +: VLEN].
- rt_uop  in  NUM_RT_UOP  per-lane retire valid.
- rt_last_uop  in  NUM_RT_UOP  per-lane last-uop-of-instruction flag (qualified by rt_uop).
- snap_req  in  1  single-cycle snapshot request.
- snap_mask  in  NUM_VREG  registers to dump; sampled with an accepted snap_req.
- snap_busy  out  1  high from request acceptance until snap_done.
- dump_valid  out  1  beat valid.
- dump_ready  in  1  beat accept.
- dump_idx  out  $clog2(NUM_VREG)  register index of the beat.
- dump_data  out  VLEN  register contents of the beat.
- dump_last  out  1  final beat of the snapshot.
- snap_done  out  1  one-cycle pulse at snapshot completion.
- snap_forced  out  1  capture was timeout-forced; held until the next accepted request.
- snap_epoch  out  8  completed-snapshot counter; wraps 255→0.
- last_uop_cnt  out  16  count of retired last uops since the previous capture, latched at capture; saturates at 0xFFFF.

Behaviour:
- Reset: state IDLE; all outputs 0; shadow buffer contents don't-care; internal counters 0.
- IDLE:
  - snap_req=1 → latch snap_mask, clear snap_forced, snap_busy=1 from the next cycle, go to WAIT_QUIET.
  - snap_req in any other state is ignored, with no queueing.
- WAIT_QUIET, capture condition is rt_uop==0 or quiet counter reaching QUIET_TIMEOUT-1. When the condition holds, on that clock edge:
  - the shadow buffer loads vrf_rd_data_full;
  - last_uop_cnt is updated;
  - the running count is cleared;
  - state moves to STREAM, or to DONE when the mask is 0.
- WAIT_QUIET, timeout capture additionally sets snap_forced=1. The quiet counter increments each WAIT_QUIET cycle with rt_uop≠0 and clears on leaving.
- Running last-uop count: adds popcount(rt_uop & rt_last_uop) every cycle in every state, saturating.
- Minimum latency: snap_req at cycle N with quiet retire at N+1 → dump_valid=1 at N+2.
- STREAM:
  - dump_idx = lowest set bit of the remaining mask; dump_data = shadow[dump_idx].
  - dump_last = 1 when no other remaining bits are set.
  - dump_valid is held and the payload is stable until dump_ready.
  - On valid&ready, clear that mask bit; on the last beat go to DONE. Back-to-back beats are allowed (one per cycle when ready is held high).
- DONE (one cycle): snap_done=1, snap_epoch increments, snap_busy=0 next cycle, return to IDLE.
- Live VRF changes after capture never affect dumped data.
- Asynchronous reset mid-operation aborts immediately: outputs return to reset values, no snap_done, epoch reset to 0.

Decomposition:
- Shared package rvv_vrf_snap_pkg holds:
  - state enum {IDLE, WAIT_QUIET, STREAM, DONE};
  - VREG_IDX_W localparam;
  - vreg_t (logic [VLEN-1:0]) and epoch_t typedefs.
- Sub-module rvv_vrf_ffs: combinational find-first-set over NUM_VREG bits. Outputs are index, found, and a more_than_one flag, which drives dump_idx and dump_last.

Test Plan:
- Full-register dump:
  - Stimulus: backdoor-write reg i = {VLEN/32{32'hA5A50000+i}}; snap_req with mask 32'hFFFF_FFFF, rt_uop=0, ready=1.
  - Response: 32 consecutive beats, idx 0..31 with matching data; dump_last only on idx 31; snap_done next cycle; snap_epoch=1.
- Sparse mask with backpressure:
  - Stimulus: mask 32'h8000_0011; dump_ready toggles 1,0,0,1.
  - Response: beats in order idx 0, 4, 31; payload stable while stalled; dump_last only with idx 31.
- Quiescence wait:
  - Stimulus: rt_uop=4'b0011 for 10 cycles after the request, then 0; reg 5 is rewritten at cycle 12.
  - Response: capture at the first quiet cycle; dumped reg 5 holds the pre-rewrite value; snap_forced=0.
- Forced capture:
  - Stimulus: QUIET_TIMEOUT=64 with rt_uop held nonzero.
  - Response: capture after 64 WAIT_QUIET cycles; snap_forced=1.
- Count, empty mask and ignored request:
  - Stimulus: 7 cycles of rt_uop=rt_last_uop=4'b0101 before the request; mask 0; second snap_req while busy.
  - Response: last_uop_cnt=14; no dump beats; snap_done pulses once; the second request is ignored.
- Reset mid-stream:
  - Stimulus: rst_n low after 3 of 32 beats.
  - Response: dump_valid, snap_busy and snap_epoch go to 0 immediately; no snap_done; a new request after reset works normally.
